mem_access_unit: RTL and testbench

CPU-side initiator for the 16-bit `mem16` word memory. It accepts LC-3b load/store requests from the datapath: word or byte, with byte loads sign-extended. It sequences them onto the memory's single-port address/write/data interface, performing read-modify-write for byte stores because `mem16` writes only whole words. It sits between the MAR/MDR logic and `mem16`, and is the driving end of that memory interface.

---
 rtl/mem_access_unit.sv | 170 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: LC-3b load/store sequencer driving the single-port mem16
// word memory. It handles word and byte accesses. Byte loads are
// sign-extended. Byte stores are done as a read-modify-write.
//
// Optional feature: define MAU_ALIGN_CHECK_EN to reject word accesses at odd
// addresses with resp_err. Without the macro, addr[0] is ignored for word
// accesses and resp_err stays 0.
module mem_access_unit #(
   parameter int MEM_LAT = 1            // cycles from address to valid mem_rdata, 1..7
) (
   input  logic        clk,
   input  logic        reset,           // asynchronous, active low
   // request side (MAR/MDR logic)
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic        req_byte,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   // response side
   output logic        resp_valid,
   output logic [15:0] resp_rdata,
   output logic        resp_err,
   // mem16 interface
   output logic [15:0] mem_addr,
   output logic        mem_write,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata
);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RMW_RD,
      WR,
      RESP
   } state_t;

   // The wait counter reaches this value in the last read cycle.
   localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

   state_t     state;
   logic [2:0] cnt;       // read wait counter
   logic       lane_q;    // captured addr[0]: selects the byte lane
   logic       byte_q;    // captured req_byte
   logic [7:0] wbyte_q;   // captured store byte for read-modify-write
   logic       misaligned;

   // A misaligned word access is only an error when the check is built in.
`ifdef MAU_ALIGN_CHECK_EN
   assign misaligned = ~req_byte & req_addr[0];
`else
   assign misaligned = 1'b0;
`endif

   // Shape a fetched word into the load result.
   // A byte load takes the selected lane and sign-extends it.
   function automatic logic [15:0] format_load(input logic [15:0] word,
                                               input logic        is_byte,
                                               input logic        lane);
      logic [7:0] b;
      b = lane ? word[15:8] : word[7:0];
      return is_byte ? {{8{b[7]}}, b} : word;
   endfunction

   // Replace one byte lane of a fetched word.
   // The other lane is kept unchanged.
   function automatic logic [15:0] merge_byte(input logic [15:0] word,
                                              input logic [7:0]  b,
                                              input logic        lane);
      return lane ? {b, word[7:0]} : {word[15:8], b};
   endfunction

   // Transaction sequencer: one FSM with all interface outputs registered.
   // NOTE: the reset is asynchronous, so a transaction cut off mid-flight
   // drops mem_write and resp_valid at once, without waiting for a clock edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         lane_q     <= 1'b0;
         byte_q     <= 1'b0;
         wbyte_q    <= '0;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         mem_addr   <= '0;
         mem_write  <= 1'b0;
         mem_wdata  <= '0;
      end else begin
         // NOTE: every state register uses non-blocking assignment. All
         // right-hand sides then see pre-edge values, whatever the statement
         // order. A later assignment in the same pass overrides an earlier one.
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  lane_q    <= req_addr[0];
                  byte_q    <= req_byte;
                  wbyte_q   <= req_wdata[7:0];
                  cnt       <= '0;
                  if (misaligned) begin
                     // No memory cycle. Answer with the error straight away.
                     resp_valid <= 1'b1;
                     resp_rdata <= '0;
                     resp_err   <= 1'b1;
                     state      <= RESP;
                  end else begin
                     mem_addr <= {req_addr[15:1], 1'b0};
                     if (!req_we) begin
                        state <= RD;
                     end else if (!req_byte) begin
                        mem_wdata <= req_wdata;
                        mem_write <= 1'b1;
                        state     <= WR;
                     end else begin
                        state <= RMW_RD;
                     end
                  end
               end
            end

            RD: begin
               if (cnt == LAT_LAST) begin
                  resp_rdata <= format_load(mem_rdata, byte_q, lane_q);
                  resp_err   <= 1'b0;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end

            RMW_RD: begin
               if (cnt == LAT_LAST) begin
                  mem_wdata <= merge_byte(mem_rdata, wbyte_q, lane_q);
                  mem_write <= 1'b1;
                  state     <= WR;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end

            WR: begin
               mem_write  <= 1'b0;
               resp_rdata <= '0;
               resp_err   <= 1'b0;
               resp_valid <= 1'b1;
               state      <= RESP;
            end

            RESP: begin
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
               state      <= IDLE;
            end

            default: begin
               mem_write  <= 1'b0;
               resp_valid <= 1'b0;
               req_ready  <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: drives two copies of mem_access_unit, one with MEM_LAT=1
// and one with MEM_LAT=3, from the same request stream. Each copy has a mem16
// stand-in and a transaction-level reference model. Compile with
// MAU_ALIGN_CHECK_EN defined to exercise the alignment-error path.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic        req_byte = 1'b0;
   logic [15:0] req_addr = '0;
   logic [15:0] req_wdata = '0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

`ifdef MAU_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   // What one accepted request must produce, counted in cycles after acceptance.
   typedef struct packed {
      logic [3:0]  resp_k;   // cycle of resp_valid
      logic [3:0]  wr_k;     // cycle of mem_write, 0 = no write
      logic        rd;       // a memory read takes place
      logic        err;
      logic [15:0] addr;     // word address on mem_addr
      logic [15:0] wdata;
      logic [15:0] rdata;
   } txn_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Derive the expected behaviour directly from the request and the current memory word.
   function automatic txn_t predict(input logic we, input logic byt, input logic [15:0] addr,
                                    input logic [15:0] wdata, input logic [15:0] old, input int lat);
      txn_t t;
      logic [7:0] b;
      t = '0;
      t.addr = {addr[15:1], 1'b0};
      b = addr[0] ? old[15:8] : old[7:0];
      if (ALIGN && !byt && addr[0]) begin
         t.resp_k = 4'd1;
         t.err    = 1'b1;
      end else if (!we) begin
         t.rd     = 1'b1;
         t.resp_k = 4'(lat + 1);
         t.rdata  = byt ? {{8{b[7]}}, b} : old;
      end else if (!byt) begin
         t.wr_k   = 4'd1;
         t.resp_k = 4'd2;
         t.wdata  = wdata;
      end else begin
         t.rd     = 1'b1;
         t.wr_k   = 4'(lat + 1);
         t.resp_k = 4'(lat + 2);
         t.wdata  = addr[0] ? {wdata[7:0], old[7:0]} : {old[15:8], wdata[7:0]};
      end
      return t;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int LAT = (g == 0) ? 1 : 3;

      logic        rdy, rv, re, mw;
      logic [15:0] rd, ma, mwd, mrd;
      logic [15:0] emu  [0:15];   // mem16 stand-in, window 0x0040..0x005F
      logic [15:0] refm [0:15];   // reference memory contents
      logic        busy = 1'b0;
      logic        up = 1'b0;
      logic [3:0]  k = '0;
      txn_t        ex = '0;
      int          n_resp = 0, n_wr = 0;
      logic [3:0]  obs_k = '0, obs_wr_k = '0;
      logic [15:0] obs_rdata = '0, obs_wdata = '0;
      logic        obs_err = 1'b0;

      mem_access_unit #(.MEM_LAT(LAT)) dut (
         .clk        (clk),
         .reset      (reset),
         .req_valid  (req_valid),
         .req_ready  (rdy),
         .req_we     (req_we),
         .req_byte   (req_byte),
         .req_addr   (req_addr),
         .req_wdata  (req_wdata),
         .resp_valid (rv),
         .resp_rdata (rd),
         .resp_err   (re),
         .mem_addr   (ma),
         .mem_write  (mw),
         .mem_wdata  (mwd),
         .mem_rdata  (mrd)
      );

      // Read data is valid only in the last cycle of the MEM_LAT read window.
      // Any other cycle returns a poison value.
      assign mrd = (busy && ex.rd && k == 4'(LAT)) ? emu[ma[4:1]] : 16'hDEAD;

      // mem16 stand-in: the word is written on the edge that ends a mem_write cycle.
      always @(posedge clk) begin
         if (mw) emu[ma[4:1]] <= mwd;
      end

      // Reference model: tracks the in-flight transaction and the memory contents.
      always @(posedge clk or negedge reset) begin
         if (!reset) begin
            busy <= 1'b0;
            up   <= 1'b0;
            k    <= '0;
         end else begin
            up <= 1'b1;
            if (busy) begin
               if (k == ex.wr_k) refm[ex.addr[4:1]] <= ex.wdata;
               if (k == ex.resp_k) busy <= 1'b0;
               else k <= k + 4'd1;
            end else if (up && req_valid) begin
               ex   <= predict(req_we, req_byte, req_addr, req_wdata, refm[req_addr[4:1]], LAT);
               busy <= 1'b1;
               k    <= 4'd1;
            end
         end
      end

      // Compare the DUT against the model on every falling edge.
      always @(negedge clk) begin
         if (!reset) begin
            check($sformatf("L%0d rst req_ready", g), 32'(rdy), 32'd0);
            check($sformatf("L%0d rst resp_valid", g), 32'(rv), 32'd0);
            check($sformatf("L%0d rst mem_write", g), 32'(mw), 32'd0);
            check($sformatf("L%0d rst mem_addr", g), 32'(ma), 32'd0);
            check($sformatf("L%0d rst mem_wdata", g), 32'(mwd), 32'd0);
            check($sformatf("L%0d rst resp_rdata", g), 32'(rd), 32'd0);
            check($sformatf("L%0d rst resp_err", g), 32'(re), 32'd0);
         end else begin
            check($sformatf("L%0d req_ready", g), 32'(rdy), 32'(up && !busy));
            check($sformatf("L%0d resp_valid", g), 32'(rv), 32'(busy && k == ex.resp_k));
            check($sformatf("L%0d mem_write", g), 32'(mw), 32'(busy && k == ex.wr_k));
            if (busy && k == ex.resp_k) begin
               check($sformatf("L%0d resp_rdata", g), 32'(rd), 32'(ex.rdata));
               check($sformatf("L%0d resp_err", g), 32'(re), 32'(ex.err));
            end
            if (busy && k == ex.wr_k) begin
               check($sformatf("L%0d wr mem_addr", g), 32'(ma), 32'(ex.addr));
               check($sformatf("L%0d mem_wdata", g), 32'(mwd), 32'(ex.wdata));
            end
            if (busy && ex.rd && k == 4'(LAT))
               check($sformatf("L%0d rd mem_addr", g), 32'(ma), 32'(ex.addr));
            if (rv) begin
               n_resp++;
               obs_k     = k;
               obs_rdata = rd;
               obs_err   = re;
            end
            if (mw) begin
               n_wr++;
               obs_wr_k  = k;
               obs_wdata = mwd;
            end
         end
      end
   end

   // Wait until both copies are idle. Running out of budget counts as a failure.
   task automatic wait_idle(input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         if (!lane[0].busy && !lane[1].busy) break;
         @(posedge clk); #1;
      end
      check("idle_wait", 32'(i < budget), 32'd1);
   endtask

   // Present one request for 'hold' clock edges, then wait for both copies to finish.
   task automatic issue(input logic we, input logic byt, input logic [15:0] addr,
                        input logic [15:0] wdata, input int hold);
      wait_idle(100);
      req_we    = we;
      req_byte  = byt;
      req_addr  = addr;
      req_wdata = wdata;
      req_valid = 1'b1;
      repeat (hold) @(posedge clk);
      #1;
      req_valid = 1'b0;
      wait_idle(100);
   endtask

   initial begin
      #100000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, r1, w0, w1;
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      check("ready_after_reset L0", 32'(lane[0].rdy), 32'd1);
      check("ready_after_reset L1", 32'(lane[1].rdy), 32'd1);

      // Fill the 16-word window with known values: word i = 0xA500 | i.
      for (int i = 0; i < 16; i++)
         issue(1'b1, 1'b0, 16'(16'h0040 + 2 * i), 16'(16'hA500 | i), 1);

      // Word store then word load at 0x0040.
      issue(1'b1, 1'b0, 16'h0040, 16'h1234, 1);
      check("wst wr cycle", 32'(lane[0].obs_wr_k), 32'd1);
      check("wst wdata", 32'(lane[0].obs_wdata), 32'h1234);
      check("wst resp cycle", 32'(lane[0].obs_k), 32'd2);
      issue(1'b0, 1'b0, 16'h0040, 16'h0000, 1);
      check("wld resp cycle L0", 32'(lane[0].obs_k), 32'd2);
      check("wld rdata L0", 32'(lane[0].obs_rdata), 32'h1234);
      check("wld resp cycle L1", 32'(lane[1].obs_k), 32'd4);
      check("wld rdata L1", 32'(lane[1].obs_rdata), 32'h1234);

      // Sign-extended byte loads from 0x80F0.
      issue(1'b1, 1'b0, 16'h0040, 16'h80F0, 1);
      issue(1'b0, 1'b1, 16'h0040, 16'h0000, 1);
      check("bld lo", 32'(lane[0].obs_rdata), 32'hFFF0);
      issue(1'b0, 1'b1, 16'h0041, 16'h0000, 1);
      check("bld hi", 32'(lane[1].obs_rdata), 32'hFF80);

      // Byte store 0xAB to the high lane over 0x1234.
      issue(1'b1, 1'b0, 16'h0040, 16'h1234, 1);
      issue(1'b1, 1'b1, 16'h0041, 16'h77AB, 1);
      check("bst wdata", 32'(lane[0].obs_wdata), 32'hAB34);
      check("bst wr cycle", 32'(lane[0].obs_wr_k), 32'd2);
      check("bst resp cycle", 32'(lane[0].obs_k), 32'd3);

      // Word load at an odd address.
      w0 = lane[0].n_wr;
      issue(1'b0, 1'b0, 16'h0043, 16'h0000, 1);
`ifdef MAU_ALIGN_CHECK_EN
      check("odd resp cycle", 32'(lane[0].obs_k), 32'd1);
      check("odd err", 32'(lane[0].obs_err), 32'd1);
      check("odd rdata", 32'(lane[0].obs_rdata), 32'h0000);
`else
      check("odd resp cycle", 32'(lane[0].obs_k), 32'd2);
      check("odd err", 32'(lane[0].obs_err), 32'd0);
      check("odd rdata", 32'(lane[0].obs_rdata), 32'hA501);
`endif
      check("odd no write", 32'(lane[0].n_wr - w0), 32'd0);

      // Load with req_valid held for five edges.
      // The MEM_LAT=3 copy accepts it once. The MEM_LAT=1 copy finishes and accepts it again.
      r0 = lane[0].n_resp;
      r1 = lane[1].n_resp;
      issue(1'b0, 1'b0, 16'h0044, 16'h0000, 5);
      check("hold resp count L1", 32'(lane[1].n_resp - r1), 32'd1);
      check("hold resp count L0", 32'(lane[0].n_resp - r0), 32'd2);
      check("hold rdata L1", 32'(lane[1].obs_rdata), 32'hA502);

      // Reset during the read phase of a byte store.
      wait_idle(100);
      r0 = lane[0].n_resp;
      r1 = lane[1].n_resp;
      w0 = lane[0].n_wr;
      w1 = lane[1].n_wr;
      req_we    = 1'b1;
      req_byte  = 1'b1;
      req_addr  = 16'h0046;
      req_wdata = 16'h0055;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      reset     = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      check("abort ready L0", 32'(lane[0].rdy), 32'd1);
      check("abort ready L1", 32'(lane[1].rdy), 32'd1);
      check("abort no write L0", 32'(lane[0].n_wr - w0), 32'd0);
      check("abort no write L1", 32'(lane[1].n_wr - w1), 32'd0);
      check("abort no resp L0", 32'(lane[0].n_resp - r0), 32'd0);
      check("abort no resp L1", 32'(lane[1].n_resp - r1), 32'd0);
      issue(1'b0, 1'b0, 16'h0046, 16'h0000, 1);
      check("abort word kept", 32'(lane[1].obs_rdata), 32'hA503);

      // Random requests; the reference model checks every cycle.
      for (int n = 0; n < 400; n++) begin
         logic rwe, rbyte;
         logic [15:0] raddr, rwdata;
         int hold;
         rwe    = 1'($urandom_range(0, 1));
         rbyte  = 1'($urandom_range(0, 1));
         raddr  = 16'(16'h0040 | $urandom_range(0, 31));
         rwdata = 16'($urandom);
         hold   = ($urandom_range(0, 7) == 0) ? $urandom_range(2, 5) : 1;
         issue(rwe, rbyte, raddr, rwdata, hold);
      end

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
